// File: rtl/pixel_frame_loader_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : pixel_pkg                                              |
// | Shared geometry constants, FSM encoding and pixel addressing     |
// | helper for the pixel frame loader.                               |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
package pixel_pkg;

  localparam int PIX_BITS   = 10;
  localparam int ROW_PIX    = 28;
  localparam int ROWS       = 28;
  localparam int SEL_BIT    = 5;
  localparam int OUT_SIZE   = PIX_BITS * ROW_PIX;
  localparam int FRAME_BITS = OUT_SIZE * ROWS;
  localparam int COL_BIT    = $clog2(ROW_PIX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_e;

  // Bit offset of pixel (row, col) inside the flattened frame.
  function automatic int pix_offset(input logic [SEL_BIT-1:0] row,
                                    input logic [COL_BIT-1:0] col);
    return int'(row) * OUT_SIZE + int'(col) * PIX_BITS;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_frame_loader_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Interface : pixel_frame_loader_if                                |
// | Pixel input stream, frame/row-select output to the row mux and   |
// | the row handshake toward the downstream consumer.                |
// | master = loader side, slave = environment side.                  |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
interface pixel_frame_loader_if;
  import pixel_pkg::*;

  logic [PIX_BITS-1:0]   Pix_In;
  logic                  Pix_Valid;
  logic                  Pix_Ready;
  logic [FRAME_BITS-1:0] Frame_Out;
  logic [SEL_BIT-1:0]    Row_Sel;
  logic                  Row_Valid;
  logic                  Row_Ready;

  modport master (
    input  Pix_In, Pix_Valid, Row_Ready,
    output Pix_Ready, Frame_Out, Row_Sel, Row_Valid
  );

  modport slave (
    output Pix_In, Pix_Valid, Row_Ready,
    input  Pix_Ready, Frame_Out, Row_Sel, Row_Valid
  );

endinterface
`default_nettype wire

// File: rtl/pixel_frame_loader_pos_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : pixel_pos_counter                                       |
// | Column/row position counter. In pixel mode the column advances   |
// | and carries into the row; in row_only mode just the row steps.   |
// | Both wrap to zero after the last position of the frame.          |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module pixel_pos_counter
  import pixel_pkg::*;
(
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               clr,
  input  wire logic               en,
  input  wire logic               row_only,
  output logic      [COL_BIT-1:0] col,
  output logic      [SEL_BIT-1:0] row,
  output logic                    last_row,
  output logic                    last_pix
);

  logic [COL_BIT-1:0] col_d, col_q;
  logic [SEL_BIT-1:0] row_d, row_q;
  logic               last_col;

  assign last_col = (col_q == COL_BIT'(ROW_PIX - 1));
  assign last_row = (row_q == SEL_BIT'(ROWS - 1));
  assign last_pix = last_col & last_row;
  assign col      = col_q;
  assign row      = row_q;

  // Next position: clear wins, then advance column (with carry) or row only.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (en) begin
      if (row_only || last_col) begin
        if (!row_only) begin
          col_d = '0;
        end
        row_d = last_row ? '0 : row_q + SEL_BIT'(1);
      end else begin
        col_d = col_q + COL_BIT'(1);
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pixel_frame_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : pixel_frame_loader                                      |
// | Packs a serial pixel stream into a 28x28 frame register, then    |
// | scans the rows through the external row mux with a valid/ready  |
// | handshake. Optional frame counter output Frame_Cnt is enabled by |
// | defining PIX_FRAME_CNT_EN.                                       |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module pixel_frame_loader
  import pixel_pkg::*;
(
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  Start,
  pixel_frame_loader_if.master       bus,
  output logic                       Done,
  output logic                       Busy
`ifdef PIX_FRAME_CNT_EN
  ,
  output logic [15:0]                Frame_Cnt
`endif
);

  state_e                state_d, state_q;
  logic [FRAME_BITS-1:0] frame_d, frame_q;
  logic                  pix_ready_d, pix_ready_q;
  logic                  done_d, done_q;
`ifdef PIX_FRAME_CNT_EN
  logic [15:0]           frame_cnt_d, frame_cnt_q;
`endif

  logic               cnt_clr;
  logic               cnt_en;
  logic               row_only;
  logic [COL_BIT-1:0] col;
  logic [SEL_BIT-1:0] row;
  logic               last_row;
  logic               last_pix;
  logic               pix_accept;

  // One counter serves both phases: pixel addressing while loading and
  // the row select while scanning. Row_Sel therefore follows the load
  // row during LOAD and is only meaningful to the mux while Row_Valid.
  pixel_pos_counter u_pos (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .row_only (row_only),
    .col      (col),
    .row      (row),
    .last_row (last_row),
    .last_pix (last_pix)
  );

  assign pix_accept    = bus.Pix_Valid & pix_ready_q;

  assign bus.Pix_Ready = pix_ready_q;
  assign bus.Frame_Out = frame_q;
  assign bus.Row_Sel   = row;
  assign bus.Row_Valid = (state_q == SCAN);
  assign Busy          = (state_q == LOAD) || (state_q == SCAN);
  assign Done          = done_q;
`ifdef PIX_FRAME_CNT_EN
  assign Frame_Cnt     = frame_cnt_q;
`endif

  // Next state, frame write and counter control; registered outputs are
  // derived from the next state so they line up with the state register.
  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    row_only = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = LOAD;
          cnt_clr = 1'b1;
        end
      end
      LOAD: begin
        if (pix_accept) begin
          cnt_en = 1'b1;
          frame_d[pix_offset(row, col) +: PIX_BITS] = bus.Pix_In;
          if (last_pix) begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        row_only = 1'b1;
        if (bus.Row_Ready) begin
          cnt_en = 1'b1;
          if (last_row) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    pix_ready_d = (state_d == LOAD);
    done_d      = (state_d == DONE);
`ifdef PIX_FRAME_CNT_EN
    // Count lands on the same edge that raises Done.
    frame_cnt_d = (state_d == DONE) ? frame_cnt_q + 16'd1 : frame_cnt_q;
`endif
  end

  // State and registered outputs; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      pix_ready_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef PIX_FRAME_CNT_EN
      frame_cnt_q <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      pix_ready_q <= pix_ready_d;
      done_q      <= done_d;
`ifdef PIX_FRAME_CNT_EN
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_frame_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_pixel_frame_loader                                   |
// | Directed self-checking bench for pixel_frame_loader.             |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module tb_pixel_frame_loader;
  import pixel_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic Start = 1'b0;
  logic Done;
  logic Busy;
`ifdef PIX_FRAME_CNT_EN
  logic [15:0] Frame_Cnt;
`endif

  int errors = 0;
  int checks = 0;

  pixel_frame_loader_if bus ();

  pixel_frame_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Start (Start),
    .bus   (bus),
    .Done  (Done),
    .Busy  (Busy)
`ifdef PIX_FRAME_CNT_EN
    ,
    .Frame_Cnt (Frame_Cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference frame: pixel k (row-major) carries (k + salt) mod 1024.
  function automatic logic [FRAME_BITS-1:0] exp_frame(input int salt);
    logic [FRAME_BITS-1:0] f;
    f = '0;
    for (int k = 0; k < ROWS * ROW_PIX; k++) begin
      f[k*PIX_BITS +: PIX_BITS] = PIX_BITS'((k + salt) % 1024);
    end
    return f;
  endfunction

  // Index of the first differing pixel, -1 if equal (diagnostics only).
  function automatic int first_diff(input logic [FRAME_BITS-1:0] a,
                                    input logic [FRAME_BITS-1:0] b);
    for (int k = 0; k < ROWS * ROW_PIX; k++) begin
      if (a[k*PIX_BITS +: PIX_BITS] !== b[k*PIX_BITS +: PIX_BITS]) return k;
    end
    return -1;
  endfunction

  task automatic start_frame();
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  // Feed n ramp pixels; with gaps, Pix_Valid is low on every odd cycle.
  task automatic feed(input int n, input bit gaps, input int salt, output int ready_low);
    int acc;
    int cyc;
    acc = 0;
    cyc = 0;
    ready_low = 0;
    while (acc < n && cyc < 4000) begin
      if (gaps && cyc[0]) begin
        bus.Pix_Valid = 1'b0;
      end else begin
        bus.Pix_Valid = 1'b1;
        bus.Pix_In    = PIX_BITS'((acc + salt) % 1024);
      end
      if (bus.Pix_Ready !== 1'b1) ready_low++;
      if (bus.Pix_Valid && bus.Pix_Ready === 1'b1) acc++;
      step();
      cyc++;
    end
    bus.Pix_Valid = 1'b0;
    checks++;
    if (acc != n) begin
      errors++;
      $display("FAIL feed_timeout: accepted=%0d required=%0d", acc, n);
    end
  endtask

  // Hold Row_Ready high until Done rises (bounded); ends in the Done cycle.
  task automatic run_to_done(output bit seen);
    int n;
    n = 0;
    bus.Row_Ready = 1'b1;
    while (Done !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    seen = (Done === 1'b1);
  endtask

  task automatic test_reset();
    bus.Pix_In    = '0;
    bus.Pix_Valid = 1'b0;
    bus.Row_Ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    checks++; if (bus.Pix_Ready !== 1'b0) begin errors++; $display("FAIL rst_pix_ready: got=%b want=0", bus.Pix_Ready); end
    checks++; if (bus.Row_Valid !== 1'b0) begin errors++; $display("FAIL rst_row_valid: got=%b want=0", bus.Row_Valid); end
    checks++; if (Done !== 1'b0)          begin errors++; $display("FAIL rst_done: got=%b want=0", Done); end
    checks++; if (Busy !== 1'b0)          begin errors++; $display("FAIL rst_busy: got=%b want=0", Busy); end
    checks++; if (bus.Row_Sel !== '0)     begin errors++; $display("FAIL rst_row_sel: got=%0d want=0", bus.Row_Sel); end
    checks++; if (bus.Frame_Out !== '0)   begin errors++; $display("FAIL rst_frame: first nonzero pixel=%0d want none", first_diff(bus.Frame_Out, '0)); end
  endtask

  task automatic test_ramp();
    int rl;
    int bad;
    int dones;
    logic [OUT_SIZE-1:0] row1;
    bus.Row_Ready = 1'b1;
    start_frame();
    checks++;
    if (bus.Pix_Ready !== 1'b1 || Busy !== 1'b1) begin
      errors++; $display("FAIL ramp_load_entry: pix_ready=%b busy=%b want 1 1", bus.Pix_Ready, Busy);
    end
    feed(ROWS * ROW_PIX, 1'b0, 0, rl);
    checks++; if (rl != 0) begin errors++; $display("FAIL ramp_ready_drop: low_cycles=%0d want 0", rl); end
    checks++;
    if (bus.Row_Valid !== 1'b1 || bus.Pix_Ready !== 1'b0) begin
      errors++; $display("FAIL ramp_scan_entry: row_valid=%b pix_ready=%b want 1 0", bus.Row_Valid, bus.Pix_Ready);
    end
    checks++;
    if (bus.Frame_Out !== exp_frame(0)) begin
      errors++; $display("FAIL ramp_frame: first bad pixel=%0d want none", first_diff(bus.Frame_Out, exp_frame(0)));
    end
    for (int c = 0; c < ROW_PIX; c++) row1[c*PIX_BITS +: PIX_BITS] = PIX_BITS'(28 + c);
    checks++;
    if (bus.Frame_Out[OUT_SIZE +: OUT_SIZE] !== row1) begin
      errors++; $display("FAIL ramp_row1: got=%h want=%h", bus.Frame_Out[OUT_SIZE +: OUT_SIZE], row1);
    end
    bad = 0;
    dones = 0;
    for (int i = 0; i < ROWS; i++) begin
      if (bus.Row_Sel !== SEL_BIT'(i) || bus.Row_Valid !== 1'b1) bad++;
      if (Done === 1'b1) dones++;
      step();
    end
    checks++; if (bad != 0 || dones != 0) begin errors++; $display("FAIL ramp_scan_steps: bad_cycles=%0d early_done=%0d want 0 0", bad, dones); end
    checks++;
    if (Done !== 1'b1 || bus.Row_Valid !== 1'b0 || bus.Row_Sel !== '0) begin
      errors++; $display("FAIL ramp_done: done=%b row_valid=%b row_sel=%0d want 1 0 0", Done, bus.Row_Valid, bus.Row_Sel);
    end
    step();
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      errors++; $display("FAIL ramp_after_done: done=%b busy=%b want 0 0", Done, Busy);
    end
  endtask

  task automatic test_backpressure();
    int rl;
    int bad;
    bit seen;
    bus.Row_Ready = 1'b1;
    start_frame();
    Start = 1'b1;                       // held through LOAD and into SCAN
    feed(ROWS * ROW_PIX, 1'b0, 5, rl);
    bus.Pix_Valid = 1'b1;               // junk pixels offered during SCAN
    bus.Pix_In    = 10'h3FF;
    checks++;
    if (bus.Frame_Out !== exp_frame(5)) begin
      errors++; $display("FAIL bp_frame_start_ignored: first bad pixel=%0d want none", first_diff(bus.Frame_Out, exp_frame(5)));
    end
    checks++; if (bus.Pix_Ready !== 1'b0) begin errors++; $display("FAIL bp_pix_ready_scan: got=%b want=0", bus.Pix_Ready); end
    repeat (3) step();
    checks++; if (bus.Row_Sel !== 5'd3) begin errors++; $display("FAIL bp_row3: got=%0d want=3", bus.Row_Sel); end
    bus.Row_Ready = 1'b0;
    bad = 0;
    repeat (5) begin
      step();
      if (bus.Row_Sel !== 5'd3 || bus.Row_Valid !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: bad_cycles=%0d want 0", bad); end
    bus.Row_Ready = 1'b1;
    step();
    checks++; if (bus.Row_Sel !== 5'd4) begin errors++; $display("FAIL bp_resume: got=%0d want=4", bus.Row_Sel); end
    Start = 1'b0;
    run_to_done(seen);
    bus.Pix_Valid = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL bp_done_timeout: done=%b want 1", Done); end
    checks++;
    if (bus.Frame_Out !== exp_frame(5)) begin
      errors++; $display("FAIL bp_frame_pix_ignored: first bad pixel=%0d want none", first_diff(bus.Frame_Out, exp_frame(5)));
    end
    step();
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL bp_idle: busy=%b want 0", Busy); end
  endtask

  task automatic test_reset_mid_load();
    int rl;
    bit seen;
    start_frame();
    feed(100, 1'b0, 3, rl);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (Busy !== 1'b0 || bus.Pix_Ready !== 1'b0 || Done !== 1'b0 || bus.Row_Valid !== 1'b0 || bus.Row_Sel !== '0) begin
      errors++; $display("FAIL mid_rst_ctrl: busy=%b pix_ready=%b done=%b row_valid=%b row_sel=%0d want 0 0 0 0 0",
                         Busy, bus.Pix_Ready, Done, bus.Row_Valid, bus.Row_Sel);
    end
    checks++;
    if (bus.Frame_Out !== '0) begin
      errors++; $display("FAIL mid_rst_frame: first nonzero pixel=%0d want none", first_diff(bus.Frame_Out, '0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    start_frame();
    feed(ROWS * ROW_PIX, 1'b0, 9, rl);
    checks++;
    if (bus.Frame_Out !== exp_frame(9)) begin
      errors++; $display("FAIL mid_rst_reload: first bad pixel=%0d want none", first_diff(bus.Frame_Out, exp_frame(9)));
    end
    run_to_done(seen);
    checks++; if (!seen) begin errors++; $display("FAIL mid_rst_done_timeout: done=%b want 1", Done); end
    step();
  endtask

  task automatic test_gaps();
    int rl;
    bit seen;
    start_frame();
    feed(ROWS * ROW_PIX, 1'b1, 0, rl);
    checks++;
    if (bus.Row_Valid !== 1'b1 || bus.Row_Sel !== '0) begin
      errors++; $display("FAIL gaps_scan_latency: row_valid=%b row_sel=%0d want 1 0", bus.Row_Valid, bus.Row_Sel);
    end
    checks++;
    if (bus.Frame_Out !== exp_frame(0)) begin
      errors++; $display("FAIL gaps_frame: first bad pixel=%0d want none", first_diff(bus.Frame_Out, exp_frame(0)));
    end
    run_to_done(seen);
    checks++; if (!seen) begin errors++; $display("FAIL gaps_done_timeout: done=%b want 1", Done); end
    step();
  endtask

`ifdef PIX_FRAME_CNT_EN
  task automatic test_frame_cnt();
    int rl;
    bit seen;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    checks++; if (Frame_Cnt !== 16'd0) begin errors++; $display("FAIL cnt_reset: got=%0d want=0", Frame_Cnt); end
    for (int f = 1; f <= 3; f++) begin
      start_frame();
      feed(ROWS * ROW_PIX, 1'b0, f, rl);
      run_to_done(seen);
      checks++;
      if (!seen || Frame_Cnt !== 16'(f)) begin
        errors++; $display("FAIL cnt_frame%0d: done=%b cnt=%0d want 1 %0d", f, Done, Frame_Cnt, f);
      end
      step();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ramp();
    test_backpressure();
    test_reset_mid_load();
    test_gaps();
`ifdef PIX_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pixel_frame_loader.md
Name: pixel_frame_loader

Overview:
- Upstream feeder for the row-select pixel mux stage.
- Accepts a serial 10-bit pixel stream (valid/ready), packs 28 pixels per row, and stores a 28x28 frame in a flat 7840-bit register that drives the mux data input.
- Then scans rows 0..27 by driving the mux select, with a valid/ready handshake to the downstream consumer of the selected 280-bit row.

Parameters:
- PIX_BITS, 10, bits per pixel
- ROW_PIX, 28, pixels per row
- ROWS, 28, rows per frame
- SEL_BIT, 5, row-select width (must satisfy 2^SEL_BIT >= ROWS)
- Derived, not overridable: OUT_SIZE = PIX_BITS*ROW_PIX = 280

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Start  in  1  begin loading a frame; honoured only in IDLE
- Pix_In  in  PIX_BITS  incoming pixel, row-major order
- Pix_Valid  in  1  Pix_In valid
- Pix_Ready  out  1  loader accepts a pixel this cycle
- Frame_Out  out  OUT_SIZE*ROWS  flattened frame; row r at bits [r*OUT_SIZE +: OUT_SIZE]
- Row_Sel  out  SEL_BIT  row index, drives mux Select
- Row_Valid  out  1  selected row (mux output) is valid
- Row_Ready  in  1  downstream accepts current row
- Done  out  1  one-cycle pulse after last row accepted
- Busy  out  1  high in LOAD or SCAN

Behaviour:
- Reset (async, rst_n=0): state IDLE; Frame_Out=0; Row_Sel=0; col/row counters=0; Pix_Ready=0; Row_Valid=0; Done=0; Busy=0.
- FSM states: IDLE, LOAD, SCAN, DONE.
- IDLE: Start=1 -> LOAD next cycle; counters cleared. Frame_Out retains the previous frame.
- LOAD:
  - Pix_Ready=1.
  - Accept = Pix_Valid & Pix_Ready.
  - Each accept writes Pix_In to bits [row*OUT_SIZE + col*PIX_BITS +: PIX_BITS].
  - col increments; at col=ROW_PIX-1, col wraps to 0 and row increments.
  - Accept of pixel (ROWS-1, ROW_PIX-1) -> SCAN next cycle; row counter reset to 0.
  - Gaps in Pix_Valid stall without loss.
- SCAN:
  - Row_Valid=1; Row_Sel = current row.
  - Row data is available combinationally through the mux in the same cycle.
  - Row_Valid & Row_Ready -> Row_Sel increments next cycle.
  - Row_Ready low holds Row_Sel and Row_Valid stable.
  - Accept at Row_Sel=ROWS-1 -> DONE.
- DONE: Done=1 for exactly one cycle, Row_Valid=0, Row_Sel returns to 0 -> IDLE.
- Frame_Out is written only in LOAD; it is stable throughout SCAN and after.
- Start outside IDLE is ignored. Pix_Valid outside LOAD is ignored (Pix_Ready=0).
- Latency: first row valid 1 cycle after the last pixel is accepted. Minimum frame time = 784 + 28 + 2 cycles.
- Reset mid-LOAD or mid-SCAN: immediate async return to IDLE; the partial frame is discarded (cleared).
- All outputs are registered except Row_Valid and Busy, which decode from state.

Optional Feature:
- Macro: PIX_FRAME_CNT_EN
- Defined:
  - Adds output Frame_Cnt [15:0].
  - Reset value 0.
  - Increments by 1 in the DONE cycle; wraps 16'hFFFF -> 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package pixel_pkg:
  - Constants PIX_BITS, ROW_PIX, ROWS, SEL_BIT, OUT_SIZE.
  - FSM state encoding: IDLE=2'd0, LOAD=2'd1, SCAN=2'd2, DONE=2'd3.
- Sub-module pixel_pos_counter: col/row counter pair with enable, wrap, and last-pixel flag. Reused in LOAD (pixel addressing) and SCAN (row only).

Test Plan:
- Ramp frame: Start, then 784 pixels with value (r*28+c) mod 1024 and Pix_Valid held high, Row_Ready=1 -> Row_Sel steps 0..27 on consecutive cycles; row 1 slice holds pixels 28..55; Done pulses once; Busy low after.
- Pixel gaps: Pix_Valid toggling 1/0 -> same Frame_Out as the ramp case; SCAN entered exactly 1 cycle after the 784th accept.
- Backpressure: Row_Ready low for 5 cycles at Row_Sel=3 -> Row_Sel holds 3, Row_Valid stays 1; resumes at 4 once Row_Ready rises.
- Reset mid-LOAD after 100 pixels -> all outputs at reset values; next Start + full frame loads correctly from pixel (0,0).
- Start pulsed during LOAD and SCAN -> ignored, counters undisturbed; Pix_Valid during SCAN -> Pix_Ready=0, Frame_Out unchanged.
- With PIX_FRAME_CNT_EN: 3 back-to-back frames -> Frame_Cnt = 1, 2, 3, each incrementing in its Done cycle.
